// File: rtl/instr_loader.sv
// ---------------------------------------------------------------------------
// instr_loader
//   Streams a program into instruction memory from a byte source while the CPU
//   pipeline is held. A session is: a 16-bit big-endian word count N, followed
//   by N words of four bytes each, most significant byte first.
//
// Ports
//   clk, reset          : clock and asynchronous active-high reset
//   start               : one-cycle request to begin a session
//   rx_data / rx_valid  : incoming byte stream
//   rx_ready            : byte accepted on edges where rx_valid is also high
//   wr_en/wr_addr/wr_data : one-cycle instruction-memory write
//   cpu_hold            : stalls PC and IF/ID while a session is active or failed
//   done / error        : session finished / header length out of range
//   word_count          : words written in the current session
// ---------------------------------------------------------------------------
module instr_loader #(
    parameter int unsigned MAX_WORDS = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_hold,
    output logic        done,
    output logic        error,
    output logic [15:0] word_count
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LEN   = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] WRITE = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;
    localparam logic [2:0] ERR   = 3'd5;

    logic [2:0]  state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [31:0] word_q, word_d;
    logic [15:0] word_count_q, word_count_d;

    logic        accept;
    logic [15:0] hdr_len;
    logic [15:0] next_count;

    assign accept     = rx_valid & rx_ready;
    // Full length as it stands on the edge taking the second header byte.
    assign hdr_len    = {len_q[15:8], rx_data};
    assign next_count = word_count_q + 16'd1;

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        byte_idx_d   = byte_idx_q;
        word_d       = word_q;
        word_count_d = word_count_q;

        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d      = LEN;
                    word_count_d = 16'd0;
                    byte_idx_d   = 2'd0;
                end
            end
            LEN: begin
                if (accept) begin
                    if (byte_idx_q == 2'd0) begin
                        len_d[15:8] = rx_data;
                        byte_idx_d  = 2'd1;
                    end else begin
                        len_d      = hdr_len;
                        byte_idx_d = 2'd0;
                        if (hdr_len == 16'd0) begin
                            state_d = DONE;
                        end else if ({16'd0, hdr_len} > MAX_WORDS) begin
                            state_d = ERR;
                        end else begin
                            state_d = DATA;
                        end
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    // Shifting left leaves byte 0 in [31:24] after four bytes.
                    word_d     = {word_q[23:0], rx_data};
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                word_count_d = next_count;
                state_d      = (next_count == len_q) ? DONE : DATA;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            len_q        <= 16'd0;
            byte_idx_q   <= 2'd0;
            word_q       <= 32'd0;
            word_count_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            byte_idx_q   <= byte_idx_d;
            word_q       <= word_d;
            word_count_q <= word_count_d;
        end
    end

    assign rx_ready   = (state_q == LEN) || (state_q == DATA);
    assign wr_en      = (state_q == WRITE);
    assign wr_addr    = BASE_ADDR + {14'd0, word_count_q, 2'b00};
    assign wr_data    = word_q;
    assign cpu_hold   = (state_q == LEN) || (state_q == DATA) ||
                        (state_q == WRITE) || (state_q == ERR);
    assign done       = (state_q == DONE);
    assign error      = (state_q == ERR);
    assign word_count = word_count_q;

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 256, giving the instruction-memory capacity in 32-bit words.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, giving the byte address of the first word written.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a load session.
REQ-006 SHALL have port rx_data  input  8  incoming program byte.
REQ-007 SHALL have port rx_valid  input  1  rx_data holds a valid byte.
REQ-008 SHALL have port rx_ready  output  1  loader accepts a byte this cycle.
REQ-009 SHALL have port wr_en  output  1  instruction-memory write strobe.
REQ-010 SHALL have port wr_addr  output  32  word-aligned byte address of the write.
REQ-011 SHALL have port wr_data  output  32  instruction word to write.
REQ-012 SHALL have port cpu_hold  output  1  holds the pipeline (PC and IF/ID stall) while loading.
REQ-013 SHALL have port done  output  1  load finished successfully.
REQ-014 SHALL have port error  output  1  header length out of range.
REQ-015 SHALL have port word_count  output  16  number of words written in the current session.

Function
REQ-016 SHALL implement states IDLE, LEN, DATA, WRITE, DONE, ERR.
REQ-017 SHALL transfer a byte only on a clock edge where rx_valid and rx_ready are both 1.
REQ-018 SHALL drive rx_ready = 1 only in LEN and DATA, and 0 in every other state.
REQ-019 SHALL go from IDLE, DONE or ERR to LEN on start = 1, clearing word_count, the byte index, done and error.
REQ-020 SHALL ignore start while in LEN, DATA or WRITE.
REQ-021 SHALL take the word length N from the first two bytes in LEN, most significant byte first.
REQ-022 SHALL, on the second header byte, go to DONE if N = 0, to ERR if N > MAX_WORDS, and to DATA otherwise.
REQ-023 SHALL pack data bytes big-endian: byte 0 into [31:24], then [23:16], [15:8], and byte 3 into [7:0].
REQ-024 SHALL go from DATA to WRITE on the edge that accepts the fourth byte of a word.
REQ-025 SHALL, in WRITE, assert wr_en for exactly one cycle with wr_addr = BASE_ADDR + 4*word_count and wr_data = the packed word.
REQ-026 SHALL increment word_count by 1 when leaving WRITE.
REQ-027 SHALL, on leaving WRITE, go to DONE if the incremented word_count equals N, and otherwise return to DATA.
REQ-028 SHALL hold wr_en = 0 outside WRITE; wr_addr and wr_data are don't-care when wr_en = 0.
REQ-029 SHALL drive cpu_hold = 1 in LEN, DATA, WRITE and ERR, and 0 in IDLE and DONE.
REQ-030 SHALL drive done = 1 only in DONE and error = 1 only in ERR.
REQ-031 SHALL keep partial word bytes and the byte index unchanged while rx_valid = 0; there is no timeout.
REQ-032 SHALL never write an address at or beyond BASE_ADDR + 4*MAX_WORDS.
REQ-033 SHALL compute addresses in 32-bit arithmetic and keep word_count within 16 bits; no wrap occurs because N <= MAX_WORDS.
REQ-034 SHALL treat start arriving in the same cycle as a final write as ignored, because the block is in WRITE.

Reset
REQ-035 SHALL, while reset = 1, force the state to IDLE and hold these outputs: rx_ready=0, wr_en=0, wr_addr=BASE_ADDR, wr_data=0, cpu_hold=0, done=0, error=0, word_count=0.
REQ-036 SHALL abandon any session in progress on reset, discarding the partial word without writing it.
REQ-037 SHALL leave IDLE on the first rising edge after reset deasserts only if start = 1.

Verification
REQ-038 Basic load: start; bytes 00 02 | 20 08 00 05 | AC 08 00 04 -> two wr_en pulses: (0x0, 0x20080005) then (0x4, 0xAC080004); done=1, cpu_hold=0, word_count=2.
REQ-039 Zero length: start; header 00 00 -> DONE on the edge after the second byte; no wr_en; word_count=0.
REQ-040 Overflow: MAX_WORDS=4; header 00 05 -> ERR with error=1, cpu_hold=1; no wr_en; a later start returns the block to LEN with error=0.
REQ-041 Throttled source: rx_valid toggled every other cycle during a 3-word load -> identical wr_data sequence; rx_ready=0 during every WRITE cycle.
REQ-042 Mid-load reset: assert reset after 6 data bytes of a 2-word load -> outputs take reset values immediately; exactly one write occurred.
REQ-043 BASE_ADDR=0x100, 1-word load -> wr_addr=0x100; a second start plus a 1-word load writes 0x100 again with word_count=1.
